// File: rtl/mul4_pkg.sv
// Shared constants and state encoding for the sequential 4x4 shift-add multiplier.
package mul4_pkg;

   localparam int W    = 4;
   localparam int ITER = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mul_state_t;

endpackage

// File: rtl/sum4.sv
// 4-bit ripple-carry adder; per-bit full-adder cells chained through the carry.
module sum4 (
   input  logic [3:0] A,
   input  logic [3:0] B,
   input  logic       c_in,
   output logic [3:0] S,
   output logic       c_out
);

   logic [4:0] c;

   assign c[0] = c_in;

   genvar i;
   generate
      for (i = 0; i < 4; i++) begin : g_fa
         assign S[i]   = A[i] ^ B[i] ^ c[i];
         assign c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
      end
   endgenerate

   assign c_out = c[4];

endmodule

// File: rtl/mul4_seq.sv
// Sequential 4x4 unsigned shift-add multiplier: one add+shift per cycle through sum4,
// 8-bit product registered on the final iteration with a one-cycle done pulse.
module mul4_seq
   import mul4_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   output logic [2*W-1:0] P,
   output logic         busy,
   output logic         done
);

   mul_state_t   state, state_nx;
   logic [W-1:0] m, q, acc;
   logic [1:0]   cnt;
   logic [W-1:0] add_b, add_s;
   logic         add_co;
   logic         load, step, last;
   logic [2*W:0] shifted;

   // Add stage only contributes the multiplicand when the current multiplier bit is set.
   assign add_b = q[0] ? m : '0;

   sum4 u_sum4 (
      .A     (acc),
      .B     (add_b),
      .c_in  (1'b0),
      .S     (add_s),
      .c_out (add_co)
   );

   // Carry lands in the top of ACC; Q[0] has been consumed and drops out.
   assign shifted = {add_co, add_s, q};

   always_comb begin
      state_nx = state;
      load     = 1'b0;
      step     = 1'b0;
      last     = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load     = 1'b1;
               state_nx = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            step = 1'b1;
            if (cnt == 2'(ITER - 1)) begin
               last     = 1'b1;
               state_nx = DONE;
            end
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               load     = 1'b1;
               state_nx = RUN;
            end else begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         m     <= '0;
         q     <= '0;
         acc   <= '0;
         cnt   <= '0;
         P     <= '0;
      end else begin
         state <= state_nx;
         if (load) begin
            m   <= A;
            q   <= B;
            acc <= '0;
            cnt <= '0;
         end else if (step) begin
            {acc, q} <= shifted[2*W:1];
            cnt      <= cnt + 2'd1;
         end
         if (last)
            P <= shifted[2*W:1];
      end
   end

endmodule

// File: tb/tb_mul4_seq.sv
// Self-checking bench for mul4_seq: directed corner cases plus randomized operands,
// checked against plain integer multiplication and the handshake timing.
module tb_mul4_seq;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [3:0] A = '0;
   logic [3:0] B = '0;
   logic [7:0] P;
   logic       busy;
   logic       done;

   int n_tests = 0;
   int n_fail  = 0;
   logic [7:0] prev_p = 8'h00;

   mul4_seq dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .A     (A),
      .B     (B),
      .P     (P),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %02h expected %02h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [7:0] ref_mul(input logic [3:0] a, input logic [3:0] b);
      int unsigned r;
      r = int'(a) * int'(b);
      return r[7:0];
   endfunction

   // One operation from IDLE; optional junk start with different operands in the 2nd RUN cycle.
   task automatic run_op(input logic [3:0] a, input logic [3:0] b, input bit junk);
      logic [7:0] exp_p;
      exp_p = ref_mul(a, b);
      @(negedge clk);
      A = a; B = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("busy_run", busy, 1);
         chk("done_run", done, 0);
         chk("p_hold_run", P, prev_p);
         if (junk && i == 1) begin
            A = ~a; B = ~b; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      chk("done_pulse", done, 1);
      chk("busy_done", busy, 0);
      chk("product", P, exp_p);
      prev_p = exp_p;
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      chk("busy_idle", busy, 0);
      chk("p_hold_idle", P, prev_p);
   endtask

   initial begin
      // Reset held for two cycles
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      chk("rst_p", P, 8'h00);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("quiet_busy", busy, 0);
         chk("quiet_done", done, 0);
         chk("quiet_p", P, 8'h00);
      end

      run_op(4'd3, 4'd5, 1'b0);
      chk("p_3x5", P, 8'h0F);
      run_op(4'd15, 4'd15, 1'b0);
      chk("p_15x15", P, 8'hE1);
      run_op(4'd0, 4'd9, 1'b0);
      chk("p_0x9", P, 8'h00);
      run_op(4'd9, 4'd1, 1'b0);
      chk("p_9x1", P, 8'h09);
      run_op(4'd6, 4'd7, 1'b1);
      chk("p_6x7_ignored_start", P, 8'h2A);

      // Back-to-back with start held high
      @(negedge clk);
      A = 4'd2; B = 4'd3; start = 1'b1;
      @(negedge clk);
      A = 4'd4; B = 4'd4;
      for (int i = 0; i < 4; i++) begin
         chk("b2b_busy1", busy, 1);
         @(negedge clk);
      end
      chk("b2b_done1", done, 1);
      chk("b2b_p1", P, ref_mul(4'd2, 4'd3));
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("b2b_busy2", busy, 1);
         chk("b2b_nodone", done, 0);
         chk("b2b_hold", P, 8'h06);
         @(negedge clk);
      end
      chk("b2b_done2", done, 1);
      chk("b2b_p2", P, ref_mul(4'd4, 4'd4));
      prev_p = 8'h10;
      @(negedge clk);
      chk("b2b_idle", done, 0);

      // Reset during the 3rd RUN cycle
      @(negedge clk);
      A = 4'd15; B = 4'd15; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("midrst_p", P, 8'h00);
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("midrst_nodone", done, 0);
         chk("midrst_p_hold", P, 8'h00);
      end
      prev_p = 8'h00;

      // Randomized operands, some with a spurious start mid-operation
      for (int t = 0; t < 30; t++) begin
         logic [3:0] ra, rb;
         bit rj;
         int gap;
         ra  = 4'($urandom_range(0, 15));
         rb  = 4'($urandom_range(0, 15));
         rj  = 1'($urandom_range(0, 1));
         gap = int'($urandom_range(0, 2));
         run_op(ra, rb, rj);
         for (int g = 0; g < gap; g++) @(negedge clk);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
